// File: rtl/hcsr04_sensor_emulador.sv
// hcsr04_sensor_emulador
// Emulates an HC-SR04 ultrasonic ranger so that the trigger/echo interface
// logic driving it can be exercised without the real sensor.
//
// State table (state | meaning | db_estado):
//   ocioso       | idle, waiting for an enabled trigger      | 0000
//   mede_trigger | measuring width of the synchronized pulse | 0001
//   atraso       | emulated 40 kHz burst, echo low           | 0010
//   gera_echo    | echo high for the computed length         | 0011
//   recuperacao  | hold-off after echo, triggers ignored     | 0100
//   (illegal)    | recovers to ocioso                        | 1110
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-low
//   habilita   enable, only looked at while idle
//   trigger    asynchronous trigger from the interface under test
//   distancia  target distance in cm, captured when the trigger is accepted
//   echo       registered echo pulse
//   ocupado    high in every state except ocioso
//   medidas    count of completed echo pulses (wraps)
//   db_estado  state code for debug displays
module hcsr04_sensor_emulador #(
  parameter int unsigned TRIGGER_MIN   = 500,
  parameter int unsigned BURST_DELAY   = 10000,
  parameter int unsigned CYCLES_PER_CM = 2941,
  parameter int unsigned TIMEOUT       = 1900000,
  parameter int unsigned HOLDOFF       = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic       trigger,
  input  logic [8:0] distancia,
  output logic       echo,
  output logic       ocupado,
  output logic [7:0] medidas,
  output logic [3:0] db_estado
);

  localparam int unsigned CW = 21;

  // Timed states count down to zero, so they are loaded with (length - 1).
  localparam logic [CW-1:0] LP_ONE      = CW'(1);
  localparam logic [CW-1:0] LP_SAT      = {CW{1'b1}};
  localparam logic [CW-1:0] LP_TRIG_MIN = CW'(TRIGGER_MIN);
  localparam logic [CW-1:0] LP_BURST_TC = CW'(BURST_DELAY - 1);
  localparam logic [CW-1:0] LP_HOLD_TC  = CW'(HOLDOFF - 1);
  localparam logic [CW-1:0] LP_TIMEOUT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LP_CPC      = CW'(CYCLES_PER_CM);

  typedef enum logic [3:0] {
    OCIOSO       = 4'b0000,
    MEDE_TRIGGER = 4'b0001,
    ATRASO       = 4'b0010,
    GERA_ECHO    = 4'b0011,
    RECUPERACAO  = 4'b0100
  } estado_t;

  estado_t       r_estado;
  estado_t       w_estado_next;
  logic          r_trig_meta;
  logic          r_trig_s;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [CW-1:0] r_len;
  logic [CW-1:0] w_len_next;
  logic [CW-1:0] w_len_calc;
  logic [7:0]    r_medidas;
  logic [7:0]    w_medidas_next;
  logic          r_echo;
  logic [3:0]    w_db;

  // Out-of-range targets (0 cm or beyond 400 cm) behave like no return.
  // 400 * 2941 still fits in 21 bits, so the product never overflows.
  assign w_len_calc = ((distancia == 9'd0) || (distancia > 9'd400))
                      ? LP_TIMEOUT
                      : CW'(distancia) * LP_CPC;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_trig_meta <= 1'b0;
      r_trig_s    <= 1'b0;
    end else begin
      r_trig_meta <= trigger;
      r_trig_s    <= r_trig_meta;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado  <= OCIOSO;
      r_cnt     <= '0;
      r_len     <= '0;
      r_medidas <= '0;
      r_echo    <= 1'b0;
    end else begin
      r_estado  <= w_estado_next;
      r_cnt     <= w_cnt_next;
      r_len     <= w_len_next;
      r_medidas <= w_medidas_next;
      // Registered from the next state so echo is high exactly while in gera_echo.
      r_echo    <= (w_estado_next == GERA_ECHO);
    end
  end

  always_comb begin
    w_estado_next  = r_estado;
    w_cnt_next     = r_cnt;
    w_len_next     = r_len;
    w_medidas_next = r_medidas;
    w_db           = r_estado;
    case (r_estado)
      OCIOSO: begin
        // The cycle that sees the trigger high already counts as one.
        if (r_trig_s && habilita) begin
          w_estado_next = MEDE_TRIGGER;
          w_cnt_next    = LP_ONE;
        end
      end
      MEDE_TRIGGER: begin
        if (r_trig_s) begin
          if (r_cnt != LP_SAT) begin
            w_cnt_next = r_cnt + LP_ONE;
          end
        end else if (r_cnt >= LP_TRIG_MIN) begin
          w_estado_next = ATRASO;
          w_len_next    = w_len_calc;
          w_cnt_next    = LP_BURST_TC;
        end else begin
          w_estado_next = OCIOSO;
          w_cnt_next    = '0;
        end
      end
      ATRASO: begin
        if (r_cnt == '0) begin
          w_estado_next = GERA_ECHO;
          w_cnt_next    = r_len - LP_ONE;
        end else begin
          w_cnt_next = r_cnt - LP_ONE;
        end
      end
      GERA_ECHO: begin
        if (r_cnt == '0) begin
          w_estado_next  = RECUPERACAO;
          w_cnt_next     = LP_HOLD_TC;
          w_medidas_next = r_medidas + 8'd1;
        end else begin
          w_cnt_next = r_cnt - LP_ONE;
        end
      end
      RECUPERACAO: begin
        if (r_cnt == '0) begin
          w_estado_next = OCIOSO;
        end else begin
          w_cnt_next = r_cnt - LP_ONE;
        end
      end
      default: begin
        w_estado_next = OCIOSO;
        w_cnt_next    = '0;
        w_db          = 4'b1110;
      end
    endcase
  end

  assign echo      = r_echo;
  assign ocupado   = (r_estado != OCIOSO);
  assign medidas   = r_medidas;
  assign db_estado = w_db;

endmodule

// File: tb/tb_hcsr04_sensor_emulador.sv
// tb_hcsr04_sensor_emulador
// Directed bench for hcsr04_sensor_emulador with small timing parameters
// (TRIGGER_MIN=4, BURST_DELAY=3, CYCLES_PER_CM=2, TIMEOUT=100, HOLDOFF=5).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_hcsr04_sensor_emulador;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic       trigger;
  logic [8:0] distancia;
  logic       echo;
  logic       ocupado;
  logic [7:0] medidas;
  logic [3:0] db_estado;

  hcsr04_sensor_emulador #(
    .TRIGGER_MIN  (4),
    .BURST_DELAY  (3),
    .CYCLES_PER_CM(2),
    .TIMEOUT      (100),
    .HOLDOFF      (5)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .habilita (habilita),
    .trigger  (trigger),
    .distancia(distancia),
    .echo     (echo),
    .ocupado  (ocupado),
    .medidas  (medidas),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_med  = 0;
  int n_mede, n_atr, n_echo, n_rec, n_busy, n_bad;
  int to;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int w);
    trigger = 1'b1;
    repeat (w) tick();
    trigger = 1'b0;
  endtask

  // Samples once per cycle until the emulator has been busy and is idle
  // again, or the budget runs out (to stays 1). With disturb set, the
  // trigger is pulsed and distancia changed during the echo.
  task automatic observe(input int budget, input bit disturb);
    bit seen;
    int k_gera;
    seen = 1'b0;
    k_gera = 0;
    n_mede = 0; n_atr = 0; n_echo = 0; n_rec = 0; n_busy = 0; n_bad = 0;
    to = 1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ocupado) begin
        seen = 1'b1;
        n_busy++;
      end
      case (db_estado)
        4'b0001: n_mede++;
        4'b0010: n_atr++;
        4'b0100: n_rec++;
        default: ;
      endcase
      if (echo) n_echo++;
      if (echo && db_estado != 4'b0011) n_bad++;
      if (disturb && db_estado == 4'b0011) begin
        k_gera++;
        if (k_gera == 1) begin
          trigger   = 1'b1;
          distancia = 9'd5;
        end
        if (k_gera == 5) trigger = 1'b0;
      end
      if (seen && !ocupado) begin
        to = 0;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b0; habilita = 1'b0; trigger = 1'b0; distancia = 9'd0;
    repeat (3) tick();
    check("rst_echo", echo, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_medidas", medidas, 0);
    check("rst_db", db_estado, 0);
    reset = 1'b1;
    tick();

    // Nominal measurement: 10 cm -> 20 echo cycles.
    habilita = 1'b1; distancia = 9'd10;
    pulse(6);
    observe(2000, 1'b0);
    exp_med++;
    check("nom_timeout", to, 0);
    check("nom_atraso", n_atr, 3);
    check("nom_echo", n_echo, 20);
    check("nom_recup", n_rec, 5);
    check("nom_echo_outside", n_bad, 0);
    check("nom_medidas", medidas, exp_med);
    check("nom_idle", ocupado, 0);

    // Runt pulse (3 cycles) is rejected after two observed mede cycles.
    pulse(3);
    observe(2000, 1'b0);
    check("runt_timeout", to, 0);
    check("runt_mede", n_mede, 2);
    check("runt_echo", n_echo, 0);
    check("runt_atraso", n_atr, 0);
    check("runt_medidas", medidas, exp_med);

    // Minimum accepted width.
    pulse(4);
    observe(2000, 1'b0);
    exp_med++;
    check("min_echo", n_echo, 20);
    check("min_medidas", medidas, exp_med);

    // Out-of-range and edge distances.
    distancia = 9'd0;
    pulse(6);
    observe(2000, 1'b0);
    exp_med++;
    check("d0_echo", n_echo, 100);
    distancia = 9'd450;
    pulse(6);
    observe(2000, 1'b0);
    exp_med++;
    check("d450_echo", n_echo, 100);
    distancia = 9'd400;
    pulse(6);
    observe(2000, 1'b0);
    exp_med++;
    check("d400_echo", n_echo, 800);
    distancia = 9'd401;
    pulse(6);
    observe(2000, 1'b0);
    exp_med++;
    check("d401_echo", n_echo, 100);
    check("dist_medidas", medidas, exp_med);

    // Trigger and distance change during echo must not disturb it.
    distancia = 9'd10;
    pulse(6);
    observe(2000, 1'b1);
    exp_med++;
    check("dist_timeout", to, 0);
    check("dist_echo", n_echo, 20);
    check("dist_medidas1", medidas, exp_med);
    observe(40, 1'b0);
    check("dist_no_extra_busy", n_busy, 0);
    check("dist_no_extra_echo", n_echo, 0);
    check("dist_medidas2", medidas, exp_med);

    // Disabled emulator ignores a valid trigger.
    habilita = 1'b0; distancia = 9'd10;
    pulse(6);
    observe(30, 1'b0);
    check("dis_busy", n_busy, 0);
    check("dis_echo", n_echo, 0);
    habilita = 1'b1;

    // Asynchronous reset on the 7th echo cycle.
    pulse(6);
    to = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (db_estado == 4'b0011) begin
        to = 0;
        break;
      end
    end
    check("rstmid_reach_echo", to, 0);
    repeat (6) tick();
    check("rstmid_echo_before", echo, 1);
    #2 reset = 1'b0;
    #1;
    exp_med = 0;
    check("rstmid_echo", echo, 0);
    check("rstmid_db", db_estado, 0);
    check("rstmid_ocupado", ocupado, 0);
    check("rstmid_medidas", medidas, exp_med);
    #1 reset = 1'b1;
    observe(20, 1'b0);
    check("post_rst_idle", n_busy, 0);
    pulse(6);
    observe(2000, 1'b0);
    exp_med++;
    check("post_rst_echo", n_echo, 20);
    check("post_rst_medidas", medidas, exp_med);

    // Fill the counter up to 255, then wrap to 0.
    distancia = 9'd1;
    for (int k = 0; k < 254; k++) begin
      pulse(4);
      observe(200, 1'b0);
    end
    exp_med = 255;
    check("wrap_255", medidas, exp_med);
    pulse(4);
    observe(200, 1'b0);
    exp_med = 0;
    check("wrap_echo", n_echo, 2);
    check("wrap_0", medidas, exp_med);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
